// File: rtl/ram_bus_master_pkg.sv
// Shared constants and FSM state type for the RAM bus initiator.
// Fixed widths of the 4-bit asynchronous RAM bus.
package ram_bus_master_pkg;

  localparam int RB_DATA_W  = 4;
  localparam int RB_OPRND_W = 4;
  localparam int RB_BYTE_W  = 8;
  localparam int RB_ADDR_W  = RB_OPRND_W + RB_BYTE_W;
  localparam int RB_CNT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RECOVER
  } state_t;

endpackage

// File: rtl/ram_bus_master_pad.sv
// Tri-state driver for the bidirectional RAM data bus.
// Ports: data (inout bus), out_en/out_val (drive side), in_val (sampled bus).
module ram_bus_master_pad #(
  parameter int W = 4
) (
  inout  wire  [W-1:0] data,
  input  logic         out_en,
  input  logic [W-1:0] out_val,
  output logic [W-1:0] in_val
);

  assign data   = out_en ? out_val : {W{1'bz}};
  assign in_val = data;

endmodule

// File: rtl/ram_bus_master.sv
// Initiator for the async RAM bus: sequences chips/enableRW/address/data.
// Ports: req_* handshake in, rsp_* completion out, chips/enableRW/address/data to RAM.
module ram_bus_master
  import ram_bus_master_pkg::*;
#(
  parameter int ACCESS_CYCLES = 1,
  parameter int DATA_W        = RB_DATA_W,
  parameter int OPRND_W       = RB_OPRND_W,
  parameter int BYTE_W        = RB_BYTE_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [OPRND_W-1:0]         req_oprnd,
  input  logic [BYTE_W-1:0]          req_byte,
  input  logic [DATA_W-1:0]          req_wdata,
  output logic                       rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       busy,
  output logic                       chips,
  output logic                       enableRW,
  output logic [OPRND_W+BYTE_W-1:0]  address,
  inout  wire  [DATA_W-1:0]          data
);

  state_t                state;
  state_t                state_n;
  logic [RB_CNT_W-1:0]   cnt;
  logic                  wr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     bus_in;
  logic                  out_en;

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign rsp_valid = (state == ST_RECOVER);

  // Drive spans SETUP..RECOVER so data is stable around both chips edges.
  assign out_en = wr_q && (state != ST_IDLE);

  ram_bus_master_pad #(
    .W(DATA_W)
  ) u_pad (
    .data    (data),
    .out_en  (out_en),
    .out_val (wdata_q),
    .in_val  (bus_in)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:    if (req_valid) state_n = ST_SETUP;
      ST_SETUP:   state_n = ST_ACCESS;
      ST_ACCESS:  if (cnt == '0) state_n = ST_RECOVER;
      ST_RECOVER: state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      chips     <= 1'b0;
      enableRW  <= 1'b0;
      address   <= '0;
      rsp_rdata <= '0;
      cnt       <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            address  <= {req_oprnd, req_byte};
            wdata_q  <= req_wdata;
            wr_q     <= req_write;
            enableRW <= req_write;
          end
        end
        ST_SETUP: begin
          chips <= 1'b1;
          cnt   <= RB_CNT_W'(ACCESS_CYCLES - 1);
        end
        ST_ACCESS: begin
          if (cnt == '0) begin
            chips <= 1'b0;
            if (!wr_q) rsp_rdata <= bus_in;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RECOVER: begin
          enableRW <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
